bcd_seg_scan: RTL and testbench

Downstream display stage for the cascaded BCD counter chain. It snapshots DIGITS packed BCD digits, one per counter stage's q, and time-multiplexes them onto a common-anode 7-segment display. Features:
- leading-zero blanking
- per-digit decimal point
- invalid-digit flagging
It sits between the counter cascade and the board's segment/select pins.

---
 rtl/bcd_seg_scan_pkg.sv | 27 ++
 rtl/bcd_seg_scan_if.sv | 35 +++
 rtl/bcd_seg_scan_dec.sv | 29 ++
 rtl/bcd_seg_scan.sv | 114 +++++++++++
 tb/tb_bcd_seg_scan.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_seg_scan_pkg.sv
// bcd_seg_scan_pkg
// Shared constants for the BCD display scanner.
//   SEG_BLANK  all segments off (active-low pattern)
//   SEG_DASH   only segment g lit, shown for non-BCD digit codes
//   SEG_0..9   active-low {g,f,e,d,c,b,a} patterns for decimal digits
//   is_bcd()   true when a 4-bit code is a legal decimal digit
package bcd_seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if
// Bundle between the counter cascade / board control and the display scanner.
//   bcd_in   [4*DIGITS] packed digits, bits [3:0] = least-significant digit
//   upd      snapshot strobe
//   blank_lz leading-zero blanking enable
//   dp_pos   [DIGITS] decimal point per digit
//   seg      [7] active-low segments {g,f,e,d,c,b,a}
//   dp       active-low decimal point
//   sel      [DIGITS] active-low digit enables
//   bcd_err  sticky non-BCD capture flag
// master = the side producing digits (cascade/bench), slave = the scanner.
interface bcd_seg_scan_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] bcd_in;
  logic                upd;
  logic                blank_lz;
  logic [DIGITS-1:0]   dp_pos;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   sel;
  logic                bcd_err;

  modport master (
    output bcd_in, upd, blank_lz, dp_pos,
    input  seg, dp, sel, bcd_err
  );

  modport slave (
    input  bcd_in, upd, blank_lz, dp_pos,
    output seg, dp, sel, bcd_err
  );

endinterface

// File: rtl/bcd_seg_scan_dec.sv
// bcd_to_seg7
// Combinational BCD to common-anode 7-segment decoder.
//   bcd  [4] digit code
//   seg  [7] active-low {g,f,e,d,c,b,a}; codes 10..15 show a dash
module bcd_to_seg7
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
// Snapshots DIGITS packed BCD digits and time-multiplexes them onto a
// common-anode 7-segment display, one digit per SCAN_DIV clock slot.
// Features leading-zero blanking, per-digit decimal point and a sticky
// flag for captured non-BCD codes.
//   clk      system clock
//   rst      synchronous active-high reset (display dark, flag cleared)
//   bus      bcd_seg_scan_if.slave: bcd_in/upd/blank_lz/dp_pos in,
//            seg/dp/sel/bcd_err out (all outputs registered)
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  bcd_seg_scan_if.slave bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] snap;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                tick;

  logic [3:0]          dig_cur;
  logic                blank_cur;
  logic                dp_cur;
  logic                upd_bad;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_nxt;
  logic [DIGITS-1:0]   sel_nxt;

  logic [6:0]          seg_p1;
  logic                dp_p1;
  logic [DIGITS-1:0]   sel_p1;
  logic                bcd_err_q;

  assign tick    = (div_cnt == DIV_LAST);
  assign idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;

  // Select the digit that becomes visible at the coming tick and work out
  // whether it is a leading zero. A digit is a leading zero when it and every
  // more-significant digit are zero, i.e. the snapshot shifted down to it is
  // zero; non-BCD codes are non-zero so they are never blanked.
  always_comb begin
    dig_cur   = 4'd0;
    blank_cur = 1'b0;
    dp_cur    = 1'b0;
    upd_bad   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        dig_cur   = snap[4*i +: 4];
        blank_cur = bus.blank_lz && (i != 0) && ((snap >> (4*i)) == '0);
        dp_cur    = bus.dp_pos[i];
      end
      if (!is_bcd(bus.bcd_in[4*i +: 4])) begin
        upd_bad = 1'b1;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (dig_cur),
    .seg (dec_seg)
  );

  // Blanking removes segments only; the digit stays selected and its
  // decimal point still follows dp_pos.
  assign seg_nxt = blank_cur ? SEG_BLANK : dec_seg;
  assign sel_nxt = ~(DIGITS'(1) << idx_nxt);

  // ---- stage p1: snapshot, divider, index and pin registers ----
  // The scan decode reads snap before this edge, so an upd landing in a tick
  // cycle shows up from the following slot onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      seg_p1    <= SEG_BLANK;
      dp_p1     <= 1'b1;
      sel_p1    <= '1;
      bcd_err_q <= 1'b0;
    end else begin
      if (bus.upd) begin
        snap <= bus.bcd_in;
        if (upd_bad) begin
          bcd_err_q <= 1'b1;
        end
      end
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        idx    <= idx_nxt;
        seg_p1 <= seg_nxt;
        dp_p1  <= ~dp_cur;
        sel_p1 <= sel_nxt;
      end
    end
  end

  assign bus.seg     = seg_p1;
  assign bus.dp      = dp_p1;
  assign bus.sel     = sel_p1;
  assign bus.bcd_err = bcd_err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan
// Bench for bcd_seg_scan with DIGITS=4, SCAN_DIV=4. A behavioural model
// derives the expected pins from edge counts since reset; a compare process
// checks every cycle, and literal checks pin down key display values.
module tb_bcd_seg_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic clk;
  logic rst;

  bcd_seg_scan_if #(.DIGITS(DIGITS)) bus ();

  bcd_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit chk_en = 0;

  // Decode table written out from the display rules
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  // model state
  logic [15:0] m_snap;
  logic        m_err;
  logic [6:0]  m_seg;
  logic        m_dp;
  logic [3:0]  m_sel;
  int          m_edges;
  int          m_ticks;

  function automatic logic [6:0] exp_seg(input logic [15:0] s, input int k, input logic blz);
    logic [15:0] sh;
    sh = s >> (4*k);
    if (blz && k > 0 && sh == 16'd0) return 7'h7F;
    return seg_tab[sh[3:0]];
  endfunction

  function automatic logic has_bad(input logic [15:0] v);
    logic [15:0] sh;
    for (int i = 0; i < DIGITS; i++) begin
      sh = v >> (4*i);
      if (sh[3:0] > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Edge n after reset release (n counted from 0) is a tick when
  // n mod SCAN_DIV == SCAN_DIV-1; tick number t shows digit t mod DIGITS.
  always @(posedge clk) begin
    int k;
    if (rst) begin
      m_snap = '0; m_err = 1'b0; m_seg = 7'h7F; m_dp = 1'b1; m_sel = 4'hF;
      m_edges = 0; m_ticks = 0;
    end else begin
      if (m_edges % SCAN_DIV == SCAN_DIV - 1) begin
        m_ticks = m_ticks + 1;
        k = m_ticks % DIGITS;
        m_seg = exp_seg(m_snap, k, bus.blank_lz);
        m_dp  = ~bus.dp_pos[k];
        m_sel = ~(4'd1 << k);
      end
      if (bus.upd) begin
        m_snap = bus.bcd_in;
        if (has_bad(bus.bcd_in)) m_err = 1'b1;
      end
      m_edges = m_edges + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (bus.seg !== m_seg || bus.dp !== m_dp || bus.sel !== m_sel || bus.bcd_err !== m_err)
        $display("FAIL pins @%0t: got seg=%h dp=%b sel=%h err=%b, want seg=%h dp=%b sel=%h err=%b",
                 $time, bus.seg, bus.dp, bus.sel, bus.bcd_err, m_seg, m_dp, m_sel, m_err);
      else
        passed++;
    end
  end

  task automatic check_lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else passed++;
  endtask

  // Wait until sel switches to the given value (bounded).
  task automatic wait_slot(input logic [3:0] want);
    logic [3:0] prev;
    int n;
    bit hit;
    prev = bus.sel; n = 0; hit = 0;
    while (!hit && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.sel == want && prev != want) hit = 1;
      prev = bus.sel;
    end
    if (!hit) begin
      checks++;
      $display("FAIL wait_slot: sel never became %h, now %h", want, bus.sel);
    end
  endtask

  task automatic load(input logic [15:0] v);
    @(negedge clk);
    bus.upd = 1'b1; bus.bcd_in = v;
    @(negedge clk);
    bus.upd = 1'b0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int r;
    v = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = $urandom_range(0, 15);
      v[4*i +: 4] = (r < 6) ? 4'd0 : (r < 14) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.bcd_in = '0; bus.upd = 1'b0; bus.blank_lz = 1'b0; bus.dp_pos = '0;

    // 1: reset and first tick
    repeat (5) @(negedge clk);
    chk_en = 1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_lit("dark_seg", {1'b0, bus.seg}, 8'h7F);
      check_lit("dark_sel", {4'h0, bus.sel}, 8'h0F);
      check_lit("dark_dp",  {7'h0, bus.dp},  8'h01);
    end
    @(negedge clk);
    check_lit("first_sel", {4'h0, bus.sel}, 8'h0D);

    // 2: plain digits
    load(16'h1234);
    wait_slot(4'hD); check_lit("1234_d1", {1'b0, bus.seg}, 8'h30);
    wait_slot(4'hB); check_lit("1234_d2", {1'b0, bus.seg}, 8'h24);
    wait_slot(4'h7); check_lit("1234_d3", {1'b0, bus.seg}, 8'h79);
    wait_slot(4'hE); check_lit("1234_d0", {1'b0, bus.seg}, 8'h19);

    // 3: leading-zero blanking
    bus.blank_lz = 1'b1;
    load(16'h0070);
    wait_slot(4'h7); check_lit("lz_d3", {1'b0, bus.seg}, 8'h7F);
    wait_slot(4'hE); check_lit("lz_d0", {1'b0, bus.seg}, 8'h40);
    wait_slot(4'hD); check_lit("lz_d1", {1'b0, bus.seg}, 8'h78);
    wait_slot(4'hB); check_lit("lz_d2", {1'b0, bus.seg}, 8'h7F);
    bus.blank_lz = 1'b0;
    wait_slot(4'h7); check_lit("nolz_d3", {1'b0, bus.seg}, 8'h40);
    wait_slot(4'hB); check_lit("nolz_d2", {1'b0, bus.seg}, 8'h40);

    // 5: decimal point, also on a blanked digit
    bus.dp_pos = 4'b0100;
    bus.blank_lz = 1'b1;
    wait_slot(4'hB);
    check_lit("dp_on",  {7'h0, bus.dp}, 8'h00);
    check_lit("dp_blk", {1'b0, bus.seg}, 8'h7F);
    wait_slot(4'h7); check_lit("dp_off", {7'h0, bus.dp}, 8'h01);

    // 4: invalid digit and sticky error
    load(16'h00A5);
    check_lit("err_set", {7'h0, bus.bcd_err}, 8'h01);
    wait_slot(4'hD); check_lit("dash", {1'b0, bus.seg}, 8'h3F);
    load(16'h0005);
    wait_slot(4'hE); check_lit("err_sticky", {7'h0, bus.bcd_err}, 8'h01);

    // 6: upd in the tick cycle, then reset mid-slot
    bus.blank_lz = 1'b0; bus.dp_pos = '0;
    wait_slot(4'hB);
    n = 0;
    while (m_edges % SCAN_DIV != SCAN_DIV - 1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    bus.upd = 1'b1; bus.bcd_in = 16'h8888;
    @(negedge clk);
    bus.upd = 1'b0;
    check_lit("coinc_sel", {4'h0, bus.sel}, 8'h07);
    check_lit("coinc_old", {1'b0, bus.seg}, 8'h40);
    wait_slot(4'hE); check_lit("coinc_new", {1'b0, bus.seg}, 8'h00);
    wait_slot(4'hD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_lit("rst_seg", {1'b0, bus.seg}, 8'h7F);
    check_lit("rst_sel", {4'h0, bus.sel}, 8'h0F);
    check_lit("rst_dp",  {7'h0, bus.dp},  8'h01);
    check_lit("rst_err", {7'h0, bus.bcd_err}, 8'h00);

    // randomized traffic with occasional resets
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      bus.upd = ($urandom_range(0, 7) == 0);
      if (bus.upd) bus.bcd_in = rand_bcd();
      if ($urandom_range(0, 23) == 0) bus.blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 23) == 0) bus.dp_pos = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.upd = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
